tree_switch_node: RTL and testbench

- Parametrised, buffered tree-NoC router node: NumChild child ports plus one parent port, each a full-duplex valid/ready stream.
- Generalises the fixed 4-leaf hierarchical leaf: child count, address span and buffer depth are parameters.
- Adds per-input FIFO buffering, round-robin output arbitration and misroute detection.
- Nodes chain through parent ports to build arbitrary-radix trees of PEs.

---
 rtl/tree_switch_node.sv | 161 ++++++++++++++++
 tb/tb_tree_switch_node.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tree_switch_node.sv
// tree_switch_node: buffered tree-NoC router with NumChild child ports and one
// parent port; per-input FIFOs feed round-robin arbitrated output registers.
module tree_switch_node #(
   parameter int DataWidth     = 35,
   parameter int AddrWidth     = 3,
   parameter int NumChild      = 4,
   parameter int ChildSpanLog2 = 0,
   parameter int BaseAddr      = 0,
   parameter int FifoDepth     = 4
) (
   input  logic                          i_sclk,
   input  logic                          i_reset,
   input  logic [NumChild*DataWidth-1:0] i_child_data,
   input  logic [NumChild-1:0]           i_child_data_valid,
   output logic [NumChild-1:0]           o_child_data_ready,
   output logic [NumChild*DataWidth-1:0] o_child_data,
   output logic [NumChild-1:0]           o_child_data_valid,
   input  logic [NumChild-1:0]           i_child_data_ready,
   input  logic [DataWidth-1:0]          i_parent_data,
   input  logic                          i_parent_data_valid,
   output logic                          o_parent_data_ready,
   output logic [DataWidth-1:0]          o_parent_data,
   output logic                          o_parent_data_valid,
   input  logic                          i_parent_data_ready,
   output logic                          o_misroute
);
   localparam int NumIn = NumChild + 1;
   localparam int PtrW  = $clog2(FifoDepth);
   localparam int SelW  = $clog2(NumIn);
   localparam int Span  = NumChild << ChildSpanLog2;

   logic [NumIn-1:0][DataWidth-1:0] in_data, head_data, out_data;
   logic [NumIn-1:0]                in_valid, in_ready;
   logic [NumIn-1:0]                out_valid, out_ready;
   logic [NumIn-1:0]                head_valid, route_req, drop, pop;
   logic [NumIn-1:0][SelW-1:0]      head_dest;
   logic [NumIn-1:0][NumIn-1:0]     grant;
   logic                            misroute_q;

   for (genvar c = 0; c < NumChild; c++) begin : g_map
      assign in_data[c] = i_child_data[c*DataWidth +: DataWidth];
      assign o_child_data[c*DataWidth +: DataWidth] = out_data[c];
   end

   assign in_data[NumChild]   = i_parent_data;
   assign in_valid            = {i_parent_data_valid, i_child_data_valid};
   assign out_ready           = {i_parent_data_ready, i_child_data_ready};
   assign o_child_data_ready  = in_ready[NumChild-1:0];
   assign o_parent_data_ready = in_ready[NumChild];
   assign o_child_data_valid  = out_valid[NumChild-1:0];
   assign o_parent_data_valid = out_valid[NumChild];
   assign o_parent_data       = out_data[NumChild];
   assign o_misroute          = misroute_q;

   for (genvar g = 0; g < NumIn; g++) begin : g_in
      logic [DataWidth-1:0] mem [FifoDepth];
      logic [PtrW-1:0]      wr_ptr, rd_ptr;
      logic [PtrW:0]        count, count_nx;
      logic                 ready_q, push, in_range;
      logic [AddrWidth-1:0] addr;
      logic [31:0]          off;

      assign push     = in_valid[g] & ready_q;
      assign count_nx = count + (PtrW+1)'(push) - (PtrW+1)'(pop[g]);
      assign in_ready[g] = ready_q;

      // ready is registered from the next occupancy, so it never looks at valid
      always_ff @(posedge i_sclk or negedge i_reset) begin
         if (!i_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
         end else begin
            if (push)
               wr_ptr <= wr_ptr + PtrW'(1);
            if (pop[g])
               rd_ptr <= rd_ptr + PtrW'(1);
            count   <= count_nx;
            ready_q <= (count_nx != (PtrW+1)'(FifoDepth));
         end
      end

      always_ff @(posedge i_sclk) begin
         if (push)
            mem[wr_ptr] <= in_data[g];
      end

      assign head_valid[g] = (count != '0);
      assign head_data[g]  = mem[rd_ptr];
      assign addr          = head_data[g][DataWidth-1 -: AddrWidth];

      // below-base addresses wrap to a huge offset and fall out of range
      assign off      = 32'(addr) - 32'(BaseAddr);
      assign in_range = (off < 32'(Span));

      assign head_dest[g] = in_range ? SelW'(off >> ChildSpanLog2)
                                     : SelW'(NumChild);
      assign drop[g]      = (g == NumChild) && head_valid[g] && !in_range;
      assign route_req[g] = head_valid[g] && !drop[g];
   end

   for (genvar o = 0; o < NumIn; o++) begin : g_out
      logic [NumIn-1:0]     want;
      logic [SelW-1:0]      last, pick;
      logic                 found, load, valid_q;
      logic [DataWidth-1:0] data_q;

      always_comb begin
         want = '0;
         for (int i = 0; i < NumIn; i++)
            want[i] = route_req[i] && (head_dest[i] == SelW'(o));
      end

      // search starts one past the last grant and wraps over all inputs
      always_comb begin
         found = 1'b0;
         pick  = '0;
         for (int k = 1; k <= NumIn; k++) begin
            if (!found && want[(int'(last) + k) % NumIn]) begin
               found = 1'b1;
               pick  = SelW'((int'(last) + k) % NumIn);
            end
         end
      end

      assign load     = found && (!valid_q || out_ready[o]);
      assign grant[o] = load ? (NumIn'(1) << pick) : '0;

      always_ff @(posedge i_sclk or negedge i_reset) begin
         if (!i_reset) begin
            last    <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
         end else if (load) begin
            last    <= pick;
            valid_q <= 1'b1;
            data_q  <= head_data[pick];
         end else if (out_ready[o]) begin
            valid_q <= 1'b0;
         end
      end

      assign out_valid[o] = valid_q;
      assign out_data[o]  = data_q;
   end

   always_comb begin
      pop = drop;
      for (int o = 0; o < NumIn; o++)
         pop = pop | grant[o];
   end

   always_ff @(posedge i_sclk or negedge i_reset) begin
      if (!i_reset)
         misroute_q <= 1'b0;
      else
         misroute_q <= drop[NumChild];
   end

endmodule

// File: tb/tb_tree_switch_node.sv
// Bench for tree_switch_node: scoreboarded default node plus directed checks
// of a two-child, span-2, base-4 node.
module tb_tree_switch_node;
   localparam int DW  = 35;
   localparam int NC  = 4;
   localparam int NI  = NC + 1;
   localparam int BNC = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic [NC*DW-1:0] cd_in, cd_out;
   logic [NC-1:0]    cv_in, cr_out, cv_out, cr_in;
   logic [DW-1:0]    pd_in, pd_out;
   logic             pv_in, pr_out, pv_out, pr_in, mis;

   logic [BNC*DW-1:0] b_cd_in, b_cd_out;
   logic [BNC-1:0]    b_cv_in, b_cr_out, b_cv_out, b_cr_in;
   logic [DW-1:0]     b_pd_in, b_pd_out;
   logic              b_pv_in, b_pr_out, b_pv_out, b_pr_in, b_mis;

   tree_switch_node dut (
      .i_sclk(clk), .i_reset(rst_n),
      .i_child_data(cd_in), .i_child_data_valid(cv_in),
      .o_child_data_ready(cr_out), .o_child_data(cd_out),
      .o_child_data_valid(cv_out), .i_child_data_ready(cr_in),
      .i_parent_data(pd_in), .i_parent_data_valid(pv_in),
      .o_parent_data_ready(pr_out), .o_parent_data(pd_out),
      .o_parent_data_valid(pv_out), .i_parent_data_ready(pr_in),
      .o_misroute(mis)
   );

   tree_switch_node #(.NumChild(BNC), .ChildSpanLog2(1), .BaseAddr(4)) dut_b (
      .i_sclk(clk), .i_reset(rst_n),
      .i_child_data(b_cd_in), .i_child_data_valid(b_cv_in),
      .o_child_data_ready(b_cr_out), .o_child_data(b_cd_out),
      .o_child_data_valid(b_cv_out), .i_child_data_ready(b_cr_in),
      .i_parent_data(b_pd_in), .i_parent_data_valid(b_pv_in),
      .o_parent_data_ready(b_pr_out), .o_parent_data(b_pd_out),
      .o_parent_data_valid(b_pv_out), .i_parent_data_ready(b_pr_in),
      .o_misroute(b_mis)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] mk(input int a, input int s, input int q);
      return {3'(a), 4'(s), 28'(q)};
   endfunction

   function automatic int route(input int base, input int nc, input int sl,
                                input int a);
      if (a >= base && a < base + (nc << sl))
         return (a - base) >> sl;
      return nc;
   endfunction

   function automatic logic [DW-1:0] in_flit(input int i);
      return (i < NC) ? cd_in[i*DW +: DW] : pd_in;
   endfunction

   function automatic logic in_hs(input int i);
      return (i < NC) ? (cv_in[i] & cr_out[i]) : (pv_in & pr_out);
   endfunction

   function automatic logic in_rdy(input int i);
      return (i < NC) ? cr_out[i] : pr_out;
   endfunction

   function automatic logic [DW-1:0] out_flit(input int o);
      return (o < NC) ? cd_out[o*DW +: DW] : pd_out;
   endfunction

   function automatic logic out_hs(input int o);
      return (o < NC) ? (cv_out[o] & cr_in[o]) : (pv_out & pr_in);
   endfunction

   function automatic int nxt_src(input int s);
      case (s)
         0:       return 1;
         1:       return 2;
         2:       return 4;
         default: return 0;
      endcase
   endfunction

   logic [DW-1:0] sb [NI][NI][$];

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NI; j++)
            n += sb[i][j].size();
      return n;
   endfunction

   logic [DW-1:0] mf;
   int ms, md;
   int acc_cnt [NI];
   int misroute_exp  = 0;
   int misroute_seen = 0;
   int cyc = 0;
   logic rot_on = 1'b0;
   int last_src = -1;
   int c3_n = 0, c3_first = 0, c3_last = 0;

   always @(posedge clk) cyc++;

   // outputs pop/compare, accepted inputs push the modelled route
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         for (int o = 0; o < NI; o++) begin
            if (out_hs(o)) begin
               mf = out_flit(o);
               ms = int'(mf[31:28]);
               if (ms >= NI) begin
                  check("out_src", 64'(ms), 64'(NI-1));
               end else begin
                  check("out_expected", 64'(sb[ms][o].size() != 0), 64'd1);
                  if (sb[ms][o].size() != 0)
                     check($sformatf("out%0d_flit", o), 64'(mf),
                           64'(sb[ms][o].pop_front()));
               end
               if (o == 3 && rot_on) begin
                  if (last_src >= 0)
                     check("rr_order", 64'(ms), 64'(nxt_src(last_src)));
                  else
                     c3_first = cyc;
                  last_src = ms;
                  c3_n++;
                  c3_last = cyc;
               end
            end
         end
         if (mis)
            misroute_seen++;
         for (int i = 0; i < NI; i++) begin
            if (in_hs(i)) begin
               mf = in_flit(i);
               md = route(0, NC, 0, int'(mf[34:32]));
               acc_cnt[i]++;
               if (i == NC && md == NC)
                  misroute_exp++;
               else
                  sb[i][md].push_back(mf);
            end
         end
      end
   end

   task automatic drive(input int s, input logic [DW-1:0] f, input logic v);
      if (s < NC) begin
         cd_in[s*DW +: DW] = f;
         cv_in[s] = v;
      end else begin
         pd_in = f;
         pv_in = v;
      end
   endtask

   task automatic send(input int s, input logic [DW-1:0] f);
      int t;
      logic r;
      t = 0;
      drive(s, f, 1'b1);
      do begin
         @(negedge clk);
         r = in_rdy(s);
         @(posedge clk);
         #1;
         t++;
      end while (!r && t < 100);
      if (!r)
         check("send_timeout", 64'(t), 64'd0);
   endtask

   task automatic stream(input int s, input int a, input int n, input int q0);
      for (int k = 0; k < n; k++)
         send(s, mk(a, s, q0 + k));
      drive(s, '0, 1'b0);
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (pending() != 0 && t < 200) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain", 64'(pending()), 64'd0);
   endtask

   function automatic logic b_rdy(input int s);
      return (s < BNC) ? b_cr_out[s] : b_pr_out;
   endfunction

   // port BNC+1 stands for the misroute pulse
   task automatic b_case(input string tag, input int src, input int a,
                         input int port);
      logic [DW-1:0] f;
      logic got;
      int t;
      f = mk(a, src, 7);
      got = 1'b0;
      t = 0;
      if (src < BNC) begin
         b_cd_in[src*DW +: DW] = f;
         b_cv_in[src] = 1'b1;
      end else begin
         b_pd_in = f;
         b_pv_in = 1'b1;
      end
      @(negedge clk);
      check({tag, "_rdy"}, 64'(b_rdy(src)), 64'd1);
      @(posedge clk);
      #1;
      b_cv_in = '0;
      b_pv_in = 1'b0;
      while (!got && t < 6) begin
         @(posedge clk);
         #1;
         t++;
         if (port > BNC)
            got = b_mis;
         else if (port == BNC)
            got = b_pv_out;
         else
            got = b_cv_out[port];
      end
      check({tag, "_seen"}, 64'(got), 64'd1);
      if (got && port < BNC)
         check({tag, "_data"}, 64'(b_cd_out[port*DW +: DW]), 64'(f));
      if (got && port == BNC)
         check({tag, "_data"}, 64'(b_pd_out), 64'(f));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] f;
      int base, stale, t;
      logic t4_done;

      rst_n = 1'b1;
      cd_in = '0; cv_in = '0; cr_in = '1;
      pd_in = '0; pv_in = 1'b0; pr_in = 1'b1;
      b_cd_in = '0; b_cv_in = '0; b_cr_in = '1;
      b_pd_in = '0; b_pv_in = 1'b0; b_pr_in = 1'b1;
      #1 rst_n = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_cvalid", 64'(cv_out), 64'd0);
      check("rst_pvalid", 64'(pv_out), 64'd0);
      check("rst_ready", 64'({pr_out, cr_out}), 64'd0);
      check("rst_cdata_nz", 64'(|cd_out), 64'd0);
      check("rst_pdata", 64'(pd_out), 64'd0);
      check("rst_mis", 64'(mis), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("rel_ready", 64'({pr_out, cr_out}), 64'h1F);
      check("rel_b_ready", 64'({b_pr_out, b_cr_out}), 64'h7);
      check("rel_valid", 64'({pv_out, cv_out}), 64'd0);

      // child0 -> child2, held while child2 stalls
      cr_in = 4'b1011;
      f = mk(2, 0, 'hA5);
      send(0, f);
      drive(0, '0, 1'b0);
      check("t1_lat_early", 64'(cv_out[2]), 64'd0);
      @(posedge clk);
      #1;
      check("t1_valid", 64'(cv_out[2]), 64'd1);
      check("t1_data", 64'(cd_out[2*DW +: DW]), 64'(f));
      repeat (3) @(posedge clk);
      #1;
      check("t1_hold_valid", 64'(cv_out[2]), 64'd1);
      check("t1_hold_data", 64'(cd_out[2*DW +: DW]), 64'(f));
      cr_in[2] = 1'b1;
      @(posedge clk);
      #1;
      check("t1_taken", 64'(cv_out[2]), 64'd0);
      wait_drain();

      // up-route, down-route, misroute
      send(1, mk(6, 1, 1));
      drive(1, '0, 1'b0);
      send(4, mk(3, 4, 2));
      drive(4, '0, 1'b0);
      wait_drain();
      send(4, mk(6, 4, 3));
      drive(4, '0, 1'b0);
      check("mis_early", 64'(mis), 64'd0);
      @(posedge clk);
      #1;
      check("mis_pulse", 64'(mis), 64'd1);
      @(posedge clk);
      #1;
      check("mis_end", 64'(mis), 64'd0);
      check("mis_no_fwd", 64'({pv_out, cv_out}), 64'd0);

      // four sources contend for child 3
      rot_on = 1'b1;
      last_src = -1;
      c3_n = 0;
      fork
         stream(0, 3, 8, 16);
         stream(1, 3, 8, 32);
         stream(2, 3, 8, 48);
         stream(4, 3, 8, 64);
      join
      wait_drain();
      rot_on = 1'b0;
      check("t3_count", 64'(c3_n), 64'd32);
      check("t3_rate", 64'(c3_last - c3_first), 64'd31);

      // backpressure: 4 FIFO slots + 1 output register
      cr_in[3] = 1'b0;
      base = acc_cnt[0];
      t4_done = 1'b0;
      fork
         begin
            stream(0, 3, 6, 80);
            t4_done = 1'b1;
         end
      join_none
      repeat (15) @(posedge clk);
      #1;
      check("t4_accepted", 64'(acc_cnt[0] - base), 64'd5);
      check("t4_ready", 64'(cr_out[0]), 64'd0);
      cr_in[3] = 1'b1;
      t = 0;
      while (!t4_done && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("t4_done", 64'(t4_done), 64'd1);
      wait_drain();

      // two-child node, span 2, base 4
      b_case("b_a5", 0, 5, 0);
      b_case("b_a6", 0, 6, 1);
      b_case("b_a1", 1, 1, 2);
      b_case("b_par5", 2, 5, 0);
      b_case("b_mis", 2, 1, 3);

      // reset with flits buffered
      cr_in = '0;
      pr_in = 1'b0;
      fork
         stream(0, 2, 3, 90);
         stream(1, 6, 3, 95);
      join
      @(posedge clk);
      check("t6_pre", 64'(cv_out[2]), 64'd1);
      #3;
      rst_n = 1'b0;
      #1;
      check("t6_cvalid", 64'(cv_out), 64'd0);
      check("t6_pvalid", 64'(pv_out), 64'd0);
      check("t6_ready", 64'({pr_out, cr_out}), 64'd0);
      for (int i = 0; i < NI; i++)
         for (int j = 0; j < NI; j++)
            sb[i][j].delete();
      cr_in = '1;
      pr_in = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      stale = 0;
      repeat (10) begin
         @(posedge clk);
         #1;
         if (|cv_out || pv_out)
            stale++;
      end
      check("t6_stale", 64'(stale), 64'd0);
      check("misroute_count", 64'(misroute_seen), 64'(misroute_exp));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
